// File: rtl/single_mem_arbiter.sv
// single_mem_arbiter
// Shares one single-port instruction/data memory between the fetch stage and
// the load/store stage. A winning request is latched into command registers,
// the memory controls are driven for exactly one ACCESS cycle, and the read
// data is returned with a one-cycle ack in RESP.
//
// Optional feature: define ARB_FAIRNESS_EN to add a 4-bit streak counter that
// forces a fetch grant after MAX_DATA_STREAK consecutive data grants made
// while a fetch waits. Without the macro, data has strict priority.
//
// Handshake (both requesters): req rises with a stable payload and stays high
// until the matching ack is seen; ack is a one-cycle pulse, rdata is valid in
// that cycle and holds until the next capture for the same requester. The
// requester may drop req or present a new request the cycle after ack. While
// a requester's ack is high its req is ignored by arbitration.

module single_mem_arbiter #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [8:0]  if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [8:0]  d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        mem_is_inst,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic [8:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_inst_data,
   input  logic [31:0] mem_ld_data,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;

   // Command registers: the granted access, held from grant until the next grant.
   logic        cmd_inst_q;
   logic        cmd_we_q;
   logic [2:0]  cmd_funct3_q;
   logic [8:0]  cmd_addr_q;
   logic [31:0] cmd_wdata_q;

   logic        arb_en;
   logic        if_pend;
   logic        d_pend;
   logic        grant_d;
   logic        grant_i;
   logic        force_fetch;

   generate
      if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
         $error("MAX_DATA_STREAK must be in 1..15");
      end
   endgenerate

   // Pending requests, with the requester being acked masked out of arbitration.
   always_comb begin
      arb_en  = (state_q == IDLE) || (state_q == RESP);
      if_pend = if_req && !((state_q == RESP) && cmd_inst_q);
      d_pend  = d_req  && !((state_q == RESP) && !cmd_inst_q);
   end

`ifdef ARB_FAIRNESS_EN
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
   logic [3:0] streak_q;

   assign force_fetch = if_pend && (streak_q >= STREAK_MAX);

   // Saturating count of back-to-back data grants taken while a fetch waits.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= 4'd0;
      end else if (grant_i) begin
         streak_q <= 4'd0;
      end else if (grant_d) begin
         if (!if_pend) begin
            streak_q <= 4'd0;
         end else if (streak_q != 4'hF) begin
            streak_q <= streak_q + 4'd1;
         end
      end
   end
`else
   assign force_fetch = 1'b0;
`endif

   // Arbitration and next-state: data wins unless fairness forces a fetch.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      state_d = state_q;
      if (arb_en) begin
         grant_d = d_pend && !force_fetch;
         grant_i = if_pend && !grant_d;
      end
      case (state_q)
         IDLE:    state_d = (grant_d || grant_i) ? ACCESS : IDLE;
         ACCESS:  state_d = RESP;
         RESP:    state_d = (grant_d || grant_i) ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, command latch on grant, and read-data capture at the end of ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cmd_inst_q   <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_funct3_q <= 3'd0;
         cmd_addr_q   <= 9'd0;
         cmd_wdata_q  <= 32'd0;
         if_rdata     <= 32'd0;
         d_rdata      <= 32'd0;
      end else begin
         state_q <= state_d;
         if (grant_d) begin
            cmd_inst_q   <= 1'b0;
            cmd_we_q     <= d_we;
            cmd_funct3_q <= d_funct3;
            cmd_addr_q   <= d_addr;
            cmd_wdata_q  <= d_wdata;
         end else if (grant_i) begin
            cmd_inst_q   <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_funct3_q <= 3'b010;
            cmd_addr_q   <= if_addr;
            cmd_wdata_q  <= 32'd0;
         end
         if (state_q == ACCESS) begin
            if (cmd_inst_q) begin
               if_rdata <= mem_inst_data;
            end else if (!cmd_we_q) begin
               d_rdata <= mem_ld_data;
            end
         end
      end
   end

   // Memory controls are live only in ACCESS; address/data follow the command.
   always_comb begin
      mem_is_inst = (state_q == ACCESS) && cmd_inst_q;
      mem_read    = (state_q == ACCESS) && !cmd_inst_q && !cmd_we_q;
      mem_write   = (state_q == ACCESS) && !cmd_inst_q && cmd_we_q;
      mem_funct3  = (state_q == ACCESS) ? cmd_funct3_q : 3'd0;
      mem_addr    = cmd_addr_q;
      mem_wdata   = cmd_wdata_q;
   end

   // Acks are high for the single RESP cycle of the current winner.
   always_comb begin
      if_ack    = (state_q == RESP) && cmd_inst_q;
      d_ack     = (state_q == RESP) && !cmd_inst_q;
      dbg_state = state_q;
   end

endmodule
